// File: rtl/cmp4_stream_ctrl.sv
// -----------------------------------------------------------------------------
// cmp4_stream_ctrl
//
// Sequential front-end for an external 4-bit magnitude comparator. Samples
// arrive over a valid/ready handshake. Each sample is compared against a
// loadable threshold: both operands are driven from registers, and the
// comparator's gt/lt/eq flags are sampled back. Every result is returned as a
// 2-bit code over a second valid/ready handshake. The block also keeps
// saturating per-outcome counters and a sticky error flag, which is set when
// a sampled flag set is not one-hot.
//
// Configuration macro: CMP4_SETTLE_EN
//   defined   : a DRIVE state holds the operands for one settle cycle before
//               the flags are sampled (2-cycle result latency).
//   undefined : IDLE goes straight to SAMPLE (1-cycle result latency).
//
// Parameters
//   CNT_W      width of each saturating event counter
//
// Ports
//   clk, rst_n                 rising-edge clock, async active-low reset
//   in_valid/in_ready/in_data  sample input handshake (ready only in IDLE)
//   thr_load/thr_data          threshold load (honoured in IDLE and OUT)
//   cmp_a/cmp_b                registered operands (sample / threshold)
//   cmp_gt/cmp_lt/cmp_eq       comparator flags (1 or high-Z)
//   out_valid/out_ready/out_res result handshake; 01 lt, 10 gt, 11 eq, 00 bad
//   gt_cnt/lt_cnt/eq_cnt       saturating outcome counters
//   cnt_clr                    synchronous clear of counters and err
//   err                        sticky non-one-hot flag error
// -----------------------------------------------------------------------------
module cmp4_stream_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             thr_load,
  input  logic [3:0]       thr_data,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_res,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  input  logic             cnt_clr,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [3:0]       cmp_a_q, cmp_a_d;
  logic [3:0]       cmp_b_q, cmp_b_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_res_q, out_res_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic             err_q, err_d;

  // The flags come from a tri-state source. Only a solid logic 1 counts as
  // asserted, so Z or X reads as 0.
  logic gt_hi, lt_hi, eq_hi, one_hot;
  assign gt_hi   = (cmp_gt === 1'b1);
  assign lt_hi   = (cmp_lt === 1'b1);
  assign eq_hi   = (cmp_eq === 1'b1);
  assign one_hot = $onehot({gt_hi, lt_hi, eq_hi});

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    // NOTE: every _d starts from its _q value, so no path leaves a signal
    // unassigned and no latch is inferred.
    state_d     = state_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    gt_cnt_d    = gt_cnt_q;
    lt_cnt_d    = lt_cnt_q;
    eq_cnt_d    = eq_cnt_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        // A threshold load and a sample accept can share this edge. The new
        // threshold is what the sample is compared against.
        if (thr_load) cmp_b_d = thr_data;
        if (in_valid) begin
          cmp_a_d = in_data;
`ifdef CMP4_SETTLE_EN
          state_d = S_DRIVE;
`else
          state_d = S_SAMPLE;
`endif
        end
      end
      S_DRIVE: begin
        state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        out_valid_d = 1'b1;
        state_d     = S_OUT;
        if (one_hot) begin
          if (gt_hi) begin
            out_res_d = 2'b10;
            gt_cnt_d  = sat_inc(gt_cnt_q);
          end else if (lt_hi) begin
            out_res_d = 2'b01;
            lt_cnt_d  = sat_inc(lt_cnt_q);
          end else begin
            out_res_d = 2'b11;
            eq_cnt_d  = sat_inc(eq_cnt_q);
          end
        end else begin
          out_res_d = 2'b00;
          err_d     = 1'b1;
        end
      end
      S_OUT: begin
        if (thr_load) cmp_b_d = thr_data;
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_res_d   = 2'b00;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A clear overrides any update from SAMPLE on the same edge.
    if (cnt_clr) begin
      gt_cnt_d = '0;
      lt_cnt_d = '0;
      eq_cnt_d = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= 2'b00;
      gt_cnt_q    <= '0;
      lt_cnt_q    <= '0;
      eq_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop updates together from
      // its pre-edge value.
      state_q     <= state_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      gt_cnt_q    <= gt_cnt_d;
      lt_cnt_q    <= lt_cnt_d;
      eq_cnt_q    <= eq_cnt_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign cmp_a     = cmp_a_q;
  assign cmp_b     = cmp_b_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign gt_cnt    = gt_cnt_q;
  assign lt_cnt    = lt_cnt_q;
  assign eq_cnt    = eq_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cmp4_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cmp4_stream_ctrl
//
// Two instances share all inputs: u_dut uses the default counter width and
// u_sat uses CNT_W=2. The comparator is modelled here from the DUT operands.
// A fault mode can force gt and eq together or float all flags to Z.
//
// The reference model works at the transaction level. A sample is busy for
// LAT edges after it is accepted, then its result is presented until it is
// taken. Expected codes come from plain arithmetic on the sample and the
// threshold. Each counter is the number of events since the last clear,
// limited to the counter maximum.
// -----------------------------------------------------------------------------
module tb_cmp4_stream_ctrl;

`ifdef CMP4_SETTLE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       thr_load = 1'b0;
  logic [3:0] thr_data = '0;
  logic       out_ready = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [1:0] flag_mode = 2'd0;  // 0 normal, 1 gt+eq forced, 2 all Z

  wire        in_ready, out_valid, err;
  wire  [3:0] cmp_a, cmp_b;
  wire  [1:0] out_res;
  wire  [7:0] gt_cnt, lt_cnt, eq_cnt;
  wire        s_in_ready, s_out_valid, s_err;
  wire  [3:0] s_cmp_a, s_cmp_b;
  wire  [1:0] s_out_res;
  wire  [1:0] s_gt_cnt, s_lt_cnt, s_eq_cnt;
  wire        cmp_gt, cmp_lt, cmp_eq;

  always #5 clk = ~clk;

  assign cmp_gt = (flag_mode == 2'd2) ? 1'bz : ((flag_mode == 2'd1) ? 1'b1 : (cmp_a > cmp_b));
  assign cmp_lt = (flag_mode == 2'd2) ? 1'bz : ((flag_mode == 2'd1) ? 1'b0 : (cmp_a < cmp_b));
  assign cmp_eq = (flag_mode == 2'd2) ? 1'bz : ((flag_mode == 2'd1) ? 1'b1 : (cmp_a == cmp_b));

  cmp4_stream_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .thr_load(thr_load), .thr_data(thr_data),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .cmp_eq(cmp_eq), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt),
    .cnt_clr(cnt_clr), .err(err)
  );

  cmp4_stream_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .thr_load(thr_load), .thr_data(thr_data),
    .cmp_a(s_cmp_a), .cmp_b(s_cmp_b), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .cmp_eq(cmp_eq), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_res(s_out_res), .gt_cnt(s_gt_cnt), .lt_cnt(s_lt_cnt),
    .eq_cnt(s_eq_cnt), .cnt_clr(cnt_clr), .err(s_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_busy, m_out, m_err;
  int         m_wait;
  logic [3:0] m_a, m_thr;
  logic [1:0] m_res;
  int         m_n[3];  // events since last clear: 0 gt, 1 lt, 2 eq
  logic [1:0] got_q[$];

  function automatic int sat(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic bit m_idle();
    return !m_busy && !m_out;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_out = 0; m_err = 0; m_wait = 0;
    m_a = '0; m_thr = '0; m_res = 2'b00;
    m_n[0] = 0; m_n[1] = 0; m_n[2] = 0;
  endtask

  // Applies one clock edge using the inputs that were held during the cycle.
  task automatic model_edge();
    if (thr_load && !m_busy) m_thr = thr_data;
    if (m_idle()) begin
      if (in_valid) begin
        m_a = in_data; m_busy = 1; m_wait = LAT;
      end
    end else if (m_busy) begin
      m_wait--;
      if (m_wait == 0) begin
        m_busy = 0; m_out = 1;
        if (flag_mode != 2'd0) begin
          m_res = 2'b00; m_err = 1;
        end else if (m_a > m_thr) begin
          m_res = 2'b10; m_n[0]++;
        end else if (m_a < m_thr) begin
          m_res = 2'b01; m_n[1]++;
        end else begin
          m_res = 2'b11; m_n[2]++;
        end
      end
    end else if (out_ready) begin
      m_out = 0;
    end
    if (cnt_clr) begin
      m_n[0] = 0; m_n[1] = 0; m_n[2] = 0; m_err = 0;
    end
  endtask

  task automatic check_all();
    check("in_ready", 32'(in_ready), 32'(m_idle()));
    check("out_valid", 32'(out_valid), 32'(m_out));
    if (m_out) check("out_res", 32'(out_res), 32'(m_res));
    check("cmp_a", 32'(cmp_a), 32'(m_a));
    check("cmp_b", 32'(cmp_b), 32'(m_thr));
    check("gt_cnt", 32'(gt_cnt), sat(m_n[0], 8));
    check("lt_cnt", 32'(lt_cnt), sat(m_n[1], 8));
    check("eq_cnt", 32'(eq_cnt), sat(m_n[2], 8));
    check("err", 32'(err), 32'(m_err));
    check("sat_out_valid", 32'(s_out_valid), 32'(m_out));
    check("sat_gt_cnt", 32'(s_gt_cnt), sat(m_n[0], 2));
    check("sat_lt_cnt", 32'(s_lt_cnt), sat(m_n[1], 2));
    check("sat_eq_cnt", 32'(s_eq_cnt), sat(m_n[2], 2));
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_cmp_a", 32'(cmp_a), 0);
    check("rst_cmp_b", 32'(cmp_b), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_res", 32'(out_res), 0);
    check("rst_gt_cnt", 32'(gt_cnt), 0);
    check("rst_lt_cnt", 32'(lt_cnt), 0);
    check("rst_eq_cnt", 32'(eq_cnt), 0);
    check("rst_err", 32'(err), 0);
    check("rst_sat_out_valid", 32'(s_out_valid), 0);
  endtask

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic step(input logic iv, input logic [3:0] id, input logic tl,
                      input logic [3:0] td, input logic ordy, input logic clr);
    in_valid = iv; in_data = id; thr_load = tl; thr_data = td;
    out_ready = ordy; cnt_clr = clr;
    if (out_valid && ordy) got_q.push_back(out_res);
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [3:0] s, input logic ordy, output int acc_cyc);
    logic acc = 1'b0;
    int   n = 0;
    while (!acc && n < 20) begin
      acc = in_ready;
      step(1'b1, s, 1'b0, 4'd0, ordy, 1'b0);
      n++;
    end
    check("accept_seen", 32'(acc), 1);
    acc_cyc = cyc;
  endtask

  task automatic wait_result(input logic ordy);
    int n = 0;
    while (!out_valid && n < 10) begin
      step(1'b0, 4'd0, 1'b0, 4'd0, ordy, 1'b0);
      n++;
    end
    check("result_seen", 32'(out_valid), 1);
  endtask

  task automatic idle_step(input logic ordy);
    step(1'b0, 4'd0, 1'b0, 4'd0, ordy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         acc[3];
    int         a0;
    logic [1:0] r;
    logic [3:0] b2b[3];

    b2b[0] = 4'd3; b2b[1] = 4'd7; b2b[2] = 4'd12;

    // Reset and basic gt: threshold 5, sample 9.
    @(negedge clk);
    do_reset();
    step(1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    send(4'd9, 1'b0, a0);
    repeat (LAT) idle_step(1'b0);
    check("basic_gt_valid", 32'(out_valid), 1);
    check("basic_gt_res", 32'(out_res), 32'h2);
    check("basic_gt_cnt", 32'(gt_cnt), 1);
    check("basic_gt_err", 32'(err), 0);
    idle_step(1'b1);

    // Back-to-back stream: threshold 7, samples 3, 7, 12, out_ready high.
    step(1'b0, 4'd0, 1'b1, 4'd7, 1'b1, 1'b1);
    got_q.delete();
    for (int i = 0; i < 3; i++) send(b2b[i], 1'b1, acc[i]);
    wait_result(1'b1);
    idle_step(1'b1);
    check("b2b_period1", acc[1] - acc[0], LAT + 2);
    check("b2b_period2", acc[2] - acc[1], LAT + 2);
    check("b2b_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("b2b_res0", 32'(got_q[0]), 32'h1);
      check("b2b_res1", 32'(got_q[1]), 32'h3);
      check("b2b_res2", 32'(got_q[2]), 32'h2);
    end
    check("b2b_gt", 32'(gt_cnt), 1);
    check("b2b_lt", 32'(lt_cnt), 1);
    check("b2b_eq", 32'(eq_cnt), 1);

    // Backpressure: sample 5 vs threshold 7, result held for 5 cycles.
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    send(4'd5, 1'b0, a0);
    wait_result(1'b0);
    r = out_res;
    check("bp_res", 32'(r), 32'h1);
    repeat (5) begin
      idle_step(1'b0);
      check("bp_stable", 32'(out_res), 32'(r));
      check("bp_in_ready", 32'(in_ready), 0);
    end
    idle_step(1'b1);
    check("bp_lt_once", 32'(lt_cnt), 1);
    check("bp_gt_none", 32'(gt_cnt), 0);

    // A threshold load while the compare is in flight must be ignored.
    step(1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0);
    send(4'd4, 1'b0, a0);
    step(1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 1'b0);
    wait_result(1'b0);
    check("thr_res_old", 32'(out_res), 32'h1);
    idle_step(1'b1);
    check("thr_hold", 32'(cmp_b), 9);

    // Invalid flag sets: gt+eq forced, then all flags floating.
    flag_mode = 2'd1;
    send(4'd3, 1'b0, a0);
    wait_result(1'b0);
    check("inv_both_res", 32'(out_res), 0);
    check("inv_both_err", 32'(err), 1);
    idle_step(1'b1);
    flag_mode = 2'd2;
    send(4'd8, 1'b0, a0);
    wait_result(1'b0);
    check("inv_z_res", 32'(out_res), 0);
    idle_step(1'b1);
    flag_mode = 2'd0;
    send(4'd9, 1'b0, a0);
    wait_result(1'b0);
    check("err_sticky", 32'(err), 1);
    idle_step(1'b1);
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("clr_err", 32'(err), 0);

    // Saturation: five gt results, threshold 0.
    step(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    repeat (5) begin
      send(4'd9, 1'b1, a0);
      wait_result(1'b1);
      idle_step(1'b1);
    end
    check("sat_gt_w2", 32'(s_gt_cnt), 3);
    check("sat_gt_w8", 32'(gt_cnt), 5);

    // Reset while the sample is in SAMPLE: its result must never appear.
    send(4'd6, 1'b0, a0);
    repeat (LAT - 1) idle_step(1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (4) begin
      idle_step(1'b1);
      check("rst_no_valid", 32'(out_valid), 0);
    end

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      if (m_idle())
        flag_mode = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      step(1'($urandom_range(0, 1)), 4'($urandom),
           ($urandom_range(0, 3) == 0), 4'($urandom),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
